// File: rtl/block_mem_responder.sv
// block_mem_responder: responder end of the cache <-> data-memory line interface.
// Services one whole-line read or write at a time with a fixed LATENCY from acceptance
// to storage access. Optional feature macro: BLOCK_MEM_STATS_EN adds saturating
// rd_count / wr_count commit counters.
module block_mem_responder #(
    parameter int unsigned BLOCK_SIZE = 16,
    parameter int unsigned NUM_BLOCKS = 256,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    is_input_valid,
    input  logic [31:0]             addr,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [BLOCK_SIZE*8-1:0] din,
    output logic                    is_output_valid,
    output logic [BLOCK_SIZE*8-1:0] dout,
    output logic                    mem_ready
`ifdef BLOCK_MEM_STATS_EN
    ,
    output logic [31:0]             rd_count,
    output logic [31:0]             wr_count
`endif
);

    localparam int unsigned DATA_W = BLOCK_SIZE * 8;
    localparam int unsigned OFF_W  = $clog2(BLOCK_SIZE);
    localparam int unsigned IDX_W  = $clog2(NUM_BLOCKS);
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               op_rd_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  din_q;
    logic [DATA_W-1:0]  dout_q;
    logic               mem_ready_q, mem_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  mem_q [NUM_BLOCKS];

    logic               accept;
    logic               commit;
    logic [IDX_W-1:0]   req_idx;

    // Legal request: valid with exactly one of read/write set.
    assign accept  = (state_q == ST_IDLE) && is_input_valid && (mem_read ^ mem_write);
    // Storage access happens on the edge where the busy countdown has expired.
    assign commit  = (state_q == ST_BUSY) && (cnt_q == '0);
    // Line index: drop the byte offset, keep log2(NUM_BLOCKS) bits so addresses wrap.
    assign req_idx = IDX_W'(addr >> OFF_W);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> BUSY -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: if (commit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: registered handshake flags derived from the upcoming state.
    always_comb begin
        mem_ready_d = 1'b0;
        out_valid_d = 1'b0;
        if (state_d == ST_IDLE) begin
            mem_ready_d = 1'b1;
        end
        if ((state_d == ST_DONE) && op_rd_q) begin
            out_valid_d = 1'b1;
        end
    end

    // Output flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            mem_ready_q <= mem_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Request capture, latency countdown and read data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            op_rd_q <= 1'b0;
            idx_q   <= '0;
            din_q   <= '0;
            dout_q  <= '0;
        end else begin
            if (accept) begin
                cnt_q   <= CNT_W'(LATENCY - 1);
                op_rd_q <= mem_read;
                idx_q   <= req_idx;
                din_q   <= din;
            end else if (state_q == ST_BUSY) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end else if (op_rd_q) begin
                    dout_q <= mem_q[idx_q];
                end
            end
        end
    end

    // Line storage; deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (commit && !op_rd_q) begin
            mem_q[idx_q] <= din_q;
        end
    end

    assign mem_ready       = mem_ready_q;
    assign is_output_valid = out_valid_q;
    assign dout            = dout_q;

`ifdef BLOCK_MEM_STATS_EN
    logic [31:0] rd_count_q;
    logic [31:0] wr_count_q;

    // Saturating commit counters; illegal requests never reach commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (commit) begin
            if (op_rd_q && (rd_count_q != '1)) begin
                rd_count_q <= rd_count_q + 32'd1;
            end
            if (!op_rd_q && (wr_count_q != '1)) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_block_mem_responder.sv
// Scoreboard bench for block_mem_responder: stimulus pushes expected read lines,
// a negedge monitor pops and compares on every is_output_valid pulse.
module tb_block_mem_responder;

    localparam int unsigned BS     = 16;
    localparam int unsigned NB     = 256;
    localparam int unsigned LAT    = 4;
    localparam int unsigned DATA_W = BS * 8;

    logic              clk;
    logic              rst_n;
    logic              is_input_valid;
    logic [31:0]       addr;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] din;
    logic              is_output_valid;
    logic [DATA_W-1:0] dout;
    logic              mem_ready;
`ifdef BLOCK_MEM_STATS_EN
    logic [31:0]       rd_count;
    logic [31:0]       wr_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int rd_exp   = 0;
    int wr_exp   = 0;
    logic [DATA_W-1:0] last_rd = '0;
    logic [DATA_W-1:0] exp_q [$];

    block_mem_responder #(
        .BLOCK_SIZE(BS),
        .NUM_BLOCKS(NB),
        .LATENCY   (LAT)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .is_input_valid (is_input_valid),
        .addr           (addr),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .din            (din),
        .is_output_valid(is_output_valid),
        .dout           (dout),
        .mem_ready      (mem_ready)
`ifdef BLOCK_MEM_STATS_EN
        ,
        .rd_count       (rd_count),
        .wr_count       (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expected read.
    always @(negedge clk) begin
        if (rst_n && is_output_valid) begin
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_pulse: got pulse dout=%h expected no pulse", dout);
            end else begin
                chk("read_data", dout, exp_q.pop_front());
            end
        end
    end

    // One request with full handshake timing checks; inputs are scrambled while busy.
    task automatic do_req(input bit rd, input logic [31:0] a, input logic [DATA_W-1:0] d,
                          input logic [DATA_W-1:0] exp);
        @(negedge clk);
        chk("ready_before_req", DATA_W'(mem_ready), DATA_W'(1));
        is_input_valid = 1'b1;
        addr           = a;
        mem_read       = rd;
        mem_write      = !rd;
        din            = d;
        @(posedge clk);
        #1;
        if (rd) exp_q.push_back(exp);
        for (int i = 0; i <= int'(LAT); i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            chk("busy_ready_low", DATA_W'(mem_ready), DATA_W'(0));
            chk("valid_timing", DATA_W'(is_output_valid), DATA_W'(rd && (i == int'(LAT))));
            if (i < int'(LAT)) begin
                is_input_valid = 1'b1;
                addr           = ~a;
                din            = ~d;
            end else begin
                is_input_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("ready_after_done", DATA_W'(mem_ready), DATA_W'(1));
        chk("valid_after_done", DATA_W'(is_output_valid), DATA_W'(0));
        if (rd) begin
            last_rd = exp;
            rd_exp++;
        end else begin
            chk("dout_hold_on_write", dout, last_rd);
            wr_exp++;
        end
    endtask

    initial begin
        logic [DATA_W-1:0] p0, a5, v2, v4, vt;
        p0 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
        a5 = {16{8'hA5}};
        v2 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        v4 = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F0F_F0F0;
        vt = 128'h1357_9BDF_2468_ACE0_FEDC_BA98_7654_3210;

        rst_n          = 1'b0;
        is_input_valid = 1'b0;
        addr           = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        din            = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", DATA_W'(mem_ready), DATA_W'(1));
        chk("reset_valid", DATA_W'(is_output_valid), DATA_W'(0));
        chk("reset_dout", dout, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Known contents for the abort test, then abort a write mid-busy.
        do_req(1'b0, 32'h0000_0040, p0, '0);
        @(negedge clk);
        is_input_valid = 1'b1;
        addr           = 32'h0000_0040;
        mem_read       = 1'b0;
        mem_write      = 1'b1;
        din            = a5;
        @(posedge clk);
        #1;
        is_input_valid = 1'b0;
        chk("abort_busy", DATA_W'(mem_ready), DATA_W'(0));
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_async_ready", DATA_W'(mem_ready), DATA_W'(1));
        chk("abort_valid", DATA_W'(is_output_valid), DATA_W'(0));
        chk("abort_dout", dout, '0);
        @(negedge clk);
        rst_n   = 1'b1;
        last_rd = '0;
        rd_exp  = 0;
        wr_exp  = 0;
        repeat (LAT + 2) @(posedge clk);
        do_req(1'b1, 32'h0000_0040, '0, p0);

        // Write then read another address within the same line.
        do_req(1'b0, 32'h0000_0040, v2, '0);
        do_req(1'b1, 32'h0000_0044, '0, v2);

        // Index wrap: 0x1010 aliases 0x0010.
        do_req(1'b0, 32'h0000_0010, v4, '0);
        do_req(1'b1, 32'h0000_1010, '0, v4);

        // Top index, read through the aliased address.
        do_req(1'b0, 32'h0000_0FF0, vt, '0);
        do_req(1'b1, 32'h0000_1FFC, '0, vt);

        // Illegal requests: both ops, then neither op.
        @(negedge clk);
        is_input_valid = 1'b1;
        addr           = 32'h0000_0040;
        din            = '1;
        mem_read       = 1'b1;
        mem_write      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                @(negedge clk);
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("illegal_ready", DATA_W'(mem_ready), DATA_W'(1));
            chk("illegal_valid", DATA_W'(is_output_valid), DATA_W'(0));
        end
        is_input_valid = 1'b0;
        do_req(1'b1, 32'h0000_0048, '0, v2);
        do_req(1'b1, 32'h0000_0010, '0, v4);

`ifdef BLOCK_MEM_STATS_EN
        #1;
        chk("rd_count", DATA_W'(rd_count), DATA_W'(rd_exp));
        chk("wr_count", DATA_W'(wr_count), DATA_W'(wr_exp));
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", DATA_W'(exp_q.size()), DATA_W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
